// File: rtl/mine_reveal_sequencer.sv
// mine_reveal_sequencer
//
// Runs after game-over. It sweeps the board grid in row-major order and
// reads the mine map at each cell. For every mine it finds, it waits
// FRAMES_PER_STEP video frames and then issues one reveal write to the
// board-state RAM, so the mines appear on screen one at a time.
//
// Optional feature: define MINE_REVEAL_COUNT_EN to add the revealed_cnt
// output, which counts the writes accepted during the current sweep.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   start           one-cycle pulse that begins a sweep (ignored while busy)
//   abort           synchronous cancel; takes priority over start
//   frame_tick      one-cycle pulse per video frame
//   rd_x, rd_y      mine-map read address (the current cursor)
//   rd_mine         mine flag for the address of the previous cycle
//   wr_req          reveal-write request, held until wr_ack
//   wr_x, wr_y      cell to reveal
//   wr_ack          write accepted in this cycle
//   busy            sweep in progress
//   done            sweep finished; held until the next start
//   revealed_cnt    (MINE_REVEAL_COUNT_EN only) accepted writes this sweep
module mine_reveal_sequencer #(
  parameter int GRID_W          = 16,
  parameter int GRID_H          = 16,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        frame_tick,
  output logic [5:0]  rd_x,
  output logic [5:0]  rd_y,
  input  logic        rd_mine,
  output logic        wr_req,
  output logic [5:0]  wr_x,
  output logic [5:0]  wr_y,
  input  logic        wr_ack,
  output logic        busy,
`ifdef MINE_REVEAL_COUNT_EN
  output logic [11:0] revealed_cnt,
`endif
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, READ, CHECK, WAIT_FRAME, WRITE, DONE
  } state_t;

  localparam int CNT_W = (FRAMES_PER_STEP < 1) ? 1 : $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CNT_W-1:0] FRAME_TARGET = CNT_W'(FRAMES_PER_STEP);
  localparam logic [5:0] LAST_X = 6'(GRID_W - 1);
  localparam logic [5:0] LAST_Y = 6'(GRID_H - 1);

  state_t           state;
  state_t           state_next;
  logic [5:0]       cur_x;
  logic [5:0]       cur_y;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_cnt_inc;
  logic             last_cell;
  logic             start_ok;
  logic             wait_over;
  logic             advance;

  // The mine map is addressed straight from the cursor, so the flag for the
  // cell presented in READ arrives while the FSM sits in CHECK.
  assign rd_x = cur_x;
  assign rd_y = cur_y;

  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);
  assign wr_req = (state == WRITE);

  assign last_cell     = (cur_x == LAST_X) && (cur_y == LAST_Y);
  assign start_ok      = start && ((state == IDLE) || (state == DONE));
  assign frame_cnt_inc = frame_cnt + CNT_W'(1);
  assign wait_over     = frame_tick && (frame_cnt_inc == FRAME_TARGET);

  // Step to the next cell after an empty cell or an accepted write; the
  // last cell leaves the cursor in place since the sweep ends there.
  assign advance = !last_cell &&
                   (((state == CHECK) && !rd_mine) ||
                    ((state == WRITE) && wr_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = READ;
      end
      READ: begin
        state_next = CHECK;
      end
      CHECK: begin
        if (rd_mine)        state_next = (FRAMES_PER_STEP == 0) ? WRITE : WAIT_FRAME;
        else if (last_cell) state_next = DONE;
        else                state_next = READ;
      end
      WAIT_FRAME: begin
        if (wait_over) state_next = WRITE;
      end
      WRITE: begin
        if (wr_ack) state_next = last_cell ? DONE : READ;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort) state_next = IDLE;
  end

  // Cursor, latched reveal coordinates and frame counter. The counter only
  // advances while already in WAIT_FRAME, so a tick in the cycle that
  // enters the wait is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x     <= '0;
      cur_y     <= '0;
      wr_x      <= '0;
      wr_y      <= '0;
      frame_cnt <= '0;
    end else if (!abort) begin
      if (start_ok) begin
        cur_x <= '0;
        cur_y <= '0;
      end
      if (advance) begin
        if (cur_x == LAST_X) begin
          cur_x <= '0;
          cur_y <= cur_y + 6'd1;
        end else begin
          cur_x <= cur_x + 6'd1;
        end
      end
      if ((state == CHECK) && rd_mine) begin
        wr_x      <= cur_x;
        wr_y      <= cur_y;
        frame_cnt <= '0;
      end
      if ((state == WAIT_FRAME) && frame_tick) begin
        frame_cnt <= frame_cnt_inc;
      end
    end
  end

`ifdef MINE_REVEAL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      revealed_cnt <= '0;
    end else if (abort || start_ok) begin
      revealed_cnt <= '0;
    end else if (wr_req && wr_ack) begin
      revealed_cnt <= revealed_cnt + 12'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mine_reveal_sequencer.sv
// Directed bench for mine_reveal_sequencer with the default 16x16 grid and
// FRAMES_PER_STEP=4. The mine map and the board-RAM acknowledge are small
// behavioural models; every expected value below is a hand-derived constant.
module tb_mine_reveal_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        frame_tick;
  logic [5:0]  rd_x;
  logic [5:0]  rd_y;
  logic        rd_mine;
  logic        wr_req;
  logic [5:0]  wr_x;
  logic [5:0]  wr_y;
  logic        wr_ack;
  logic        busy;
  logic        done;
`ifdef MINE_REVEAL_COUNT_EN
  logic [11:0] revealed_cnt;
`endif

  mine_reveal_sequencer #(
    .GRID_W(16), .GRID_H(16), .FRAMES_PER_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_tick(frame_tick), .rd_x(rd_x), .rd_y(rd_y), .rd_mine(rd_mine),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_ack(wr_ack),
    .busy(busy),
`ifdef MINE_REVEAL_COUNT_EN
    .revealed_cnt(revealed_cnt),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mine map: index y*16+x, registered read (one cycle latency).
  logic [255:0] mine_map;
  always @(posedge clk) rd_mine <= mine_map[{rd_y[3:0], rd_x[3:0]}];

  // Board RAM acknowledge: asserts in the (ack_delay+1)-th cycle of a request.
  int   ack_delay;
  logic ack_en;
  int   req_age;
  always @(posedge clk) begin
    #2;
    if (wr_req && ack_en) begin
      req_age = req_age + 1;
      wr_ack  = (req_age == ack_delay + 1);
    end else begin
      req_age = 0;
      wr_ack  = 1'b0;
    end
  end

  int n_chk;
  int n_pass;

  // Statistics gathered by run_cycles.
  int         nwr;
  logic [5:0] wx [4];
  logic [5:0] wy [4];
  int         wlen [4];
  int         req_start [4];
  int         first_req;
  int         req_cycles;
  int         done_at;
  logic       unstable;
  logic       busy_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
  endtask

  // Runs n cycles after a start edge (cycle i samples the state after the
  // i-th edge). Ticks, repeated starts and a single abort are optional.
  task automatic run_cycles(input int n, input int tick_mod, input int start_mod,
                            input int abort_at);
    int run_len;
    logic [5:0] px;
    logic [5:0] py;
    nwr = 0; first_req = -1; req_cycles = 0; done_at = -1;
    unstable = 1'b0; busy_gap = 1'b0; run_len = 0; px = '0; py = '0;
    for (int k = 0; k < 4; k++) begin
      wx[k] = '0; wy[k] = '0; wlen[k] = 0; req_start[k] = -1;
    end
    for (int i = 1; i <= n; i++) begin
      frame_tick = (tick_mod != 0) && (i % tick_mod == 0);
      start      = (start_mod != 0) && (i % start_mod == 0);
      abort      = (i == abort_at);
      @(posedge clk); #3;
      if (wr_req) begin
        req_cycles++;
        if (first_req < 0) first_req = i;
        if (run_len > 0 && (wr_x != px || wr_y != py)) unstable = 1'b1;
        if (run_len == 0 && nwr < 4) req_start[nwr] = i;
        run_len++;
        px = wr_x;
        py = wr_y;
        if (wr_ack && nwr < 4) begin
          wx[nwr] = wr_x; wy[nwr] = wr_y; wlen[nwr] = run_len;
          nwr++;
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
      if (done && done_at < 0) done_at = i;
      if (!busy && done_at < 0 && abort_at == 0) busy_gap = 1'b1;
    end
    frame_tick = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_tick = 1'b0;
    mine_map = '0; ack_delay = 0; ack_en = 1'b1; req_age = 0; wr_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_rd_xy", {rd_y, rd_x}, 0);
    check("rst_wr_xy", {wr_y, wr_x}, 0);
`ifdef MINE_REVEAL_COUNT_EN
    check("rst_cnt", revealed_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #3;

    // Empty map: 2 cycles per cell, done after 512 cycles, no writes
    pulse_start();
    check("empty_busy_after_start", busy, 1);
    run_cycles(600, 7, 0, 0);
    check("empty_no_wr_req", req_cycles, 0);
    check("empty_done_at", done_at, 512);
    check("empty_busy_held", busy_gap, 0);
    check("empty_done_sticky", done, 1);

    // Single mine at (3,2); ticks every 100 cycles
    mine_map = '0;
    mine_map[2*16+3] = 1'b1;
    ack_delay = 0;
    pulse_start();
    check("start_clears_done", done, 0);
    run_cycles(900, 100, 0, 0);
    check("one_nwr", nwr, 1);
    check("one_wr_x", wx[0], 3);
    check("one_wr_y", wy[0], 2);
    check("one_req_after_4th_tick", req_start[0], 400);
    check("one_req_cycles", req_cycles, 1);
    check("one_done_at", done_at, 841);
`ifdef MINE_REVEAL_COUNT_EN
    check("one_cnt", revealed_cnt, 1);
`endif

    // Mines at (0,1) and (15,15); ack 5 cycles late; ticks every 10 cycles
    mine_map = '0;
    mine_map[1*16+0]  = 1'b1;
    mine_map[15*16+15] = 1'b1;
    ack_delay = 5;
    pulse_start();
    run_cycles(600, 10, 0, 0);
    check("two_nwr", nwr, 2);
    check("two_first_xy", {wy[0], wx[0]}, {6'd1, 6'd0});
    check("two_second_xy", {wy[1], wx[1]}, {6'd15, 6'd15});
    check("two_len0", wlen[0], 6);
    check("two_len1", wlen[1], 6);
    check("two_req0_at", req_start[0], 70);
    check("two_req1_at", req_start[1], 590);
    check("two_stable", unstable, 0);
    check("two_done_at", done_at, 596);
    check("two_busy_held", busy_gap, 0);
`ifdef MINE_REVEAL_COUNT_EN
    check("two_cnt", revealed_cnt, 2);
`endif

    // Abort while the write for (0,1) is pending
    ack_en = 1'b0;
    pulse_start();
    run_cycles(72, 10, 0, 72);
    check("abort_req_seen_at", first_req, 70);
    check("abort_wr_req", wr_req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cursor_held", rd_y, 1);
`ifdef MINE_REVEAL_COUNT_EN
    check("abort_cnt", revealed_cnt, 0);
`endif

    // Restart after abort, with extra start pulses while busy
    ack_en = 1'b1;
    pulse_start();
    check("restart_busy", busy, 1);
    check("restart_cursor", {rd_y, rd_x}, 0);
    run_cycles(600, 10, 97, 0);
    check("ign_nwr", nwr, 2);
    check("ign_first_xy", {wy[0], wx[0]}, {6'd1, 6'd0});
    check("ign_second_xy", {wy[1], wx[1]}, {6'd15, 6'd15});
    check("ign_req0_at", req_start[0], 70);
    check("ign_req1_at", req_start[1], 590);
    check("ign_done_at", done_at, 596);

    // Asynchronous reset while waiting for frames before the (0,1) write
    pulse_start();
    run_cycles(40, 10, 0, 0);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_wr_y", wr_y, 1);
    check("pre_rst_rd_y", rd_y, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_wr_req", wr_req, 0);
    check("arst_rd_xy", {rd_y, rd_x}, 0);
    check("arst_wr_xy", {wr_y, wr_x}, 0);
`ifdef MINE_REVEAL_COUNT_EN
    check("arst_cnt", revealed_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #3;
    check("post_rst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mine_reveal_sequencer.md
Name: mine_reveal_sequencer

Overview:
- On game-over, walks the board grid cell by cell and reads the mine map at each cell.
- For every mine found, waits a set number of video frames, then issues one reveal write to the board-state RAM.
- Mines therefore appear one by one on screen, each drawn by the static mine bitmap renderer.
- Sits between the game FSM (start/abort), the VGA sync generator (frame_tick), the mine map (read port) and the board-state RAM (write port).

Parameters:
- GRID_W, 16, board width in cells (1..64).
- GRID_H, 16, board height in cells (1..64).
- FRAMES_PER_STEP, 4, frame_ticks to wait before each mine reveal. 0 means no wait.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse that begins a reveal sweep
- abort  in  1  synchronous cancel of a sweep
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- rd_x  out  6  mine-map read column
- rd_y  out  6  mine-map read row
- rd_mine  in  1  mine flag for (rd_x, rd_y), valid exactly 1 cycle after the address
- wr_req  out  1  reveal-write request
- wr_x  out  6  column to reveal
- wr_y  out  6  row to reveal
- wr_ack  in  1  write accepted in this cycle
- busy  out  1  sweep in progress
- done  out  1  sweep completed; sticky

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE; rd_x, rd_y, wr_x, wr_y = 0; wr_req=0; busy=0; done=0; frame counter=0.
- States: IDLE, READ, CHECK, WAIT_FRAME, WRITE, DONE.
- busy=1 in every state except IDLE and DONE.
- IDLE/DONE + start:
  - cursor <= (0,0), done <= 0, next state READ.
  - start while busy is ignored.
- READ: drives rd_x/rd_y from the cursor; next state CHECK.
- CHECK: samples rd_mine.
  - rd_mine=1: latch wr_x/wr_y from the cursor, clear the frame counter, go to WAIT_FRAME. If FRAMES_PER_STEP=0, go straight to WRITE.
  - rd_mine=0 on the last cell (GRID_W-1, GRID_H-1): go to DONE.
  - rd_mine=0 otherwise: advance the cursor, go to READ.
- Cursor advance:
  - x increments.
  - At x=GRID_W-1, x wraps to 0 and y increments.
  - y never wraps; the sweep ends at the last cell.
- WAIT_FRAME:
  - Counter increments on each frame_tick.
  - The cycle in which a tick brings the count to FRAMES_PER_STEP moves the state to WRITE.
  - A frame_tick in the cycle of entry to WAIT_FRAME is not counted.
- WRITE:
  - wr_req=1 with wr_x/wr_y stable until the cycle in which wr_ack=1. wr_req drops the following cycle.
  - On ack: the last cell goes to DONE; otherwise advance the cursor and go to READ.
  - wr_ack outside WRITE is ignored.
- DONE: done=1, held until the next start.
- Throughput with no mines: 2 cycles per cell; 512 cycles for the default 16x16 grid.
- abort=1 in any state:
  - next state IDLE, wr_req=0 next cycle, done=0, busy=0.
  - Dropping wr_req before ack is legal only on abort; the board RAM treats it as a cancel.
- abort and start in the same cycle: abort wins.
- Reset asserted mid-sweep: all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: MINE_REVEAL_COUNT_EN.
- Defined:
  - Adds output revealed_cnt, 12 bits.
  - Cleared on start and on abort.
  - Incremented on each accepted write (wr_req & wr_ack).
  - Held through DONE; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Empty map, FRAMES_PER_STEP=4, pulse start → wr_req never asserts; done rises exactly 512 cycles after start; busy=1 throughout the sweep.
- Single mine at (3,2), frame_tick every 100 cycles → exactly one wr_req, with wr_x=3, wr_y=2, after the 4th counted tick; done=1 after the sweep ends.
- Mines at (15,15) and (0,1), wr_ack delayed 5 cycles → wr_req held 6 cycles with stable coordinates; writes occur in order (0,1) then (15,15); done follows the last ack.
- abort during WRITE for (0,1) → wr_req=0 next cycle; busy=0; done=0; a following start restarts the sweep from (0,0).
- start asserted while busy → ignored; the write sequence is unchanged from the no-start run.
- rst_n pulled low in WAIT_FRAME → all outputs at reset values in the same cycle; with MINE_REVEAL_COUNT_EN defined, revealed_cnt=0.
